reg_wb_arbiter: RTL
===================

# reg_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. It shares that port between NUM_REQ write-back requesters (ALU, load unit, multiplier, ...) using a valid/ready handshake. It registers the winning write into a one-deep commit stage that drives the register file's write enable, address and data inputs. Writes to R0 are accepted but never committed.

## Interface
- NUM_REQ, 2, number of requesters; legal 2..4
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- CNT_W, 16, width of committed-write counter

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- req_valid_in  in  NUM_REQ  per-requester write request
- req_addr_in  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data_in  in  NUM_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
- req_ready_out  out  NUM_REQ  one-hot grant; transfer = valid & ready
- stall_in  in  1  write port unavailable; blocks new grants
- reg_write_out  out  1  register file write enable
- wr_addr_out  out  ADDR_W  register file write address
- wr_data_out  out  DATA_W  register file write data
- busy_out  out  1  commit stage holds a write this cycle (equals reg_write_out)
- commit_cnt_out  out  CNT_W  count of committed writes (address != 0), wraps

## Operation
- Grant logic is combinational and depends only on req_valid_in, stall_in and the priority pointer.
  - It never depends on req_ready_out, so there is no valid/ready loop.
- stall_in = 1: req_ready_out = 0.
- stall_in = 0 and at least one valid: exactly one ready bit, on the selected valid requester.
- No valid requester: req_ready_out = 0.
- Requester rules:
  - Once a requester raises valid, it holds valid, addr and data stable until it sees ready.
  - It may not withdraw valid before that.
  - A requester with valid low is never granted.
- Priority (round-robin build):
  - The search starts at index (ptr+1) mod NUM_REQ and takes the first valid requester.
  - ptr loads the granted index on a transfer only.
  - ptr is unchanged on idle or stall cycles.
- Commit stage, on each transfer:
  - wr_addr_out and wr_data_out load the granted request's addr and data.
  - reg_write_out = 1 if addr != 0, else 0.
- With no transfer: reg_write_out = 0; wr_addr_out and wr_data_out hold their last values.
- commit_cnt_out increments by 1, modulo 2^CNT_W, on each cycle where the commit stage loads with addr != 0.
- Simultaneous requests to the same address: they serialize in grant order, so the later grant overwrites the earlier one in the register file.
- stall_in does not cancel a write already in the commit stage; that write is still issued.

## Timing
- Reset values (asynchronous on rst_i = 0):
  - reg_write_out = 0, busy_out = 0, wr_addr_out = 0, wr_data_out = 0, commit_cnt_out = 0.
  - ptr = NUM_REQ-1, so requester 0 wins first.
- Reset mid-operation: a write in the commit stage is dropped, and an in-flight handshake is lost. Requesters re-present after reset.
- Latency: a transfer at rising edge N gives reg_write_out = 1 during cycle N..N+1. The register file samples the write at edge N+1.
- Throughput: one transfer per cycle; back-to-back grants allowed, including to the same requester when it is the only one valid.
- Fairness (round-robin): a continuously valid requester is granted within NUM_REQ transfers.
- req_ready_out changes only with inputs or ptr, and is valid in the same cycle as req_valid_in.

## Configuration
- WB_ARB_RR_EN defined: round-robin priority with ptr as described.
- WB_ARB_RR_EN undefined: fixed priority, lowest index wins. ptr is not implemented, and starvation of higher indices is permitted.
- Handshake, commit stage and counter are identical in both builds.

## Test plan
- Reset: assert rst_i = 0 mid-cycle with the commit stage loaded. Outputs go to 0 immediately, without a clock, and commit_cnt_out = 0.
- Single write: req 1 valid, addr 5, data 0xDEADBEEF. Ready the same cycle; next cycle reg_write_out = 1, wr_addr_out = 5, wr_data_out = 0xDEADBEEF; commit_cnt_out = 1.
- Round-robin (RR build, NUM_REQ = 2): both valid for 4 cycles. Grants go 0, 1, 0, 1, and four consecutive commit cycles follow.
- Fixed-priority build, same stimulus: grants go 0, 0, 0, 0, and req 1 ready stays 0 throughout.
- R0 write: req 0 writes addr 0, data 0x12345678. Ready = 1, next cycle reg_write_out = 0, and commit_cnt_out is unchanged.
- Stall: both valid, stall_in = 1 for 3 cycles. req_ready_out = 0 and ptr is unchanged; an already committed write still pulses reg_write_out. After release, the grant goes to the requester after ptr.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
// Write-back arbiter for the register file's single write port. NUM_REQ
// write-back requesters compete through a valid/ready handshake. The winner
// is registered into a one-deep commit stage that drives the register file's
// write enable, address and data. Writes to R0 are accepted but never issued.
//
// Optional feature macro: WB_ARB_RR_EN
//   defined   -> round-robin priority. The search starts after the last granted index.
//   undefined -> fixed priority. The lowest valid index wins.
//
// Ports:
//   clk_i           clock, all state on rising edge
//   rst_i           asynchronous active-low reset
//   req_valid_in    per-requester write request
//   req_addr_in     packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data_in     packed data, requester i at [i*DATA_W +: DATA_W]
//   req_ready_out   one-hot grant (combinational); transfer = valid & ready
//   stall_in        write port unavailable, blocks new grants
//   reg_write_out   register file write enable
//   wr_addr_out     register file write address
//   wr_data_out     register file write data
//   busy_out        commit stage holds a write (same as reg_write_out)
//   commit_cnt_out  count of committed writes to non-zero addresses, wraps
module reg_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_in,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_in,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
  output logic [NUM_REQ-1:0]        req_ready_out,
  input  logic                      stall_in,
  output logic                      reg_write_out,
  output logic [ADDR_W-1:0]         wr_addr_out,
  output logic [DATA_W-1:0]         wr_data_out,
  output logic                      busy_out,
  output logic [CNT_W-1:0]          commit_cnt_out
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               transfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic               reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

`ifdef WB_ARB_RR_EN
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   grant_idx;

  // Rotating search starting one past the last granted index. The grant
  // never looks at req_ready_out, so there is no combinational loop.
  always_comb begin
    grant     = '0;
    found     = 1'b0;
    cand      = '0;
    grant_idx = ptr_q;
    if (!stall_in) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
        if (!found && req_valid_in[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  // The pointer only moves on a real transfer. Idle and stall cycles leave it alone.
  assign ptr_d = transfer ? grant_idx : ptr_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= PTR_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: the lowest valid index wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (!stall_in) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid_in[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
        end
      end
    end
  end
`endif

  // The grant is one-hot, so an OR-mux selects the winning request.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_addr_in[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign transfer = |grant;

  // Commit stage. Address and data hold between transfers. The enable is
  // a one-cycle pulse that is suppressed for R0.
  assign reg_write_d = transfer && (sel_addr != '0);
  assign wr_addr_d   = transfer ? sel_addr : wr_addr_q;
  assign wr_data_d   = transfer ? sel_data : wr_data_q;
  assign cnt_d       = reg_write_d ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_write_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cnt_q       <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready_out  = grant;
  assign reg_write_out  = reg_write_q;
  assign busy_out       = reg_write_q;
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;
  assign commit_cnt_out = cnt_q;

endmodule
